// File: rtl/key_expand_iter.sv
// Iterative AES-128 key schedule: latches a cipher key and streams round keys
// 0..ROUNDS over a valid/ready handshake, one new key per accepted transfer.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] TABLE = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = TABLE[a];
endmodule

module key_expand_iter #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done
);
  localparam logic [3:0] LAST = 4'(ROUNDS);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state, state_n;
  logic [127:0] key_q, next_key;
  logic [3:0]   round_q;
  logic         done_q, done_n;
  logic         load, advance;

  logic [31:0]  w0, w1, w2, w3, rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = key_q;
  assign rot = {w3[23:0], w3[31:24]};

  sbox u_sbox3 (.a(rot[31:24]), .y(sub[31:24]));
  sbox u_sbox2 (.a(rot[23:16]), .y(sub[23:16]));
  sbox u_sbox1 (.a(rot[15:8]),  .y(sub[15:8]));
  sbox u_sbox0 (.a(rot[7:0]),   .y(sub[7:0]));

  assign t  = sub ^ {rcon(round_q + 4'd1), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q == LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= done_n;
      if (load) begin
        key_q   <= key_in;
        round_q <= '0;
      end else if (advance) begin
        key_q   <= next_key;
        round_q <= round_q + 4'd1;
      end
    end
  end

  assign busy     = (state == EMIT);
  assign rk_valid = (state == EMIT);
  assign rk_round = round_q;
  assign rk_out   = key_q;
  assign done     = done_q;
endmodule

// File: tb/tb_key_expand_iter.sv
// Directed bench for key_expand_iter: FIPS-197 and zero-key schedules,
// backpressure, ignored restarts, mid-run reset and a ROUNDS=1 build.

module tb_key_expand_iter;
  logic         clk, rst_n;
  logic         start, rk_ready, busy, rk_valid, done;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_round;

  logic         start1, rk_ready1, busy1, rk_valid1, done1;
  logic [127:0] key_in1, rk_out1;
  logic [3:0]   rk_round1;

  int total = 0;
  int passed = 0;
  int fails = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips [0:10];

  key_expand_iter #(.ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_round(rk_round),
    .rk_out(rk_out), .done(done)
  );

  key_expand_iter #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key_in(key_in1), .busy(busy1),
    .rk_valid(rk_valid1), .rk_ready(rk_ready1), .rk_round(rk_round1),
    .rk_out(rk_out1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs a full FIPS expansion. mode 1 stalls with ready pattern 1,0,0,...;
  // inject re-pulses start with a different key while round 4 is presented.
  task automatic run_fips(input string name, input int mode, input int inject);
    int idx = 0;
    int c = 0;
    logic rdy;
    key_in = FIPS_KEY;
    start = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx <= 10 && c < 200) begin
      chk($sformatf("%s valid r%0d", name, idx), 128'(rk_valid), 128'(1));
      chk($sformatf("%s busy r%0d", name, idx), 128'(busy), 128'(1));
      chk($sformatf("%s done r%0d", name, idx), 128'(done), 128'(0));
      chk($sformatf("%s round r%0d", name, idx), 128'(rk_round), 128'(idx));
      chk($sformatf("%s key r%0d", name, idx), rk_out, fips[idx]);
      rdy = (mode == 0) ? 1'b1 : (c % 3 == 0);
      rk_ready = rdy;
      start = (inject != 0 && idx == 4);
      key_in = (inject != 0 && idx == 4) ? 128'hffeeddccbbaa99887766554433221100 : FIPS_KEY;
      @(negedge clk);
      c++;
      if (rdy) idx++;
    end
    start = 1'b0;
    key_in = FIPS_KEY;
    rk_ready = 1'b0;
    chk({name, " completed"}, 128'(idx), 128'(11));
    chk({name, " done pulse"}, 128'(done), 128'(1));
    chk({name, " busy at done"}, 128'(busy), 128'(0));
    chk({name, " valid at done"}, 128'(rk_valid), 128'(0));
    @(negedge clk);
    chk({name, " done one cycle"}, 128'(done), 128'(0));
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n = 1'b0;
    start = 1'b0; key_in = '0; rk_ready = 1'b0;
    start1 = 1'b0; key_in1 = '0; rk_ready1 = 1'b0;

    @(negedge clk);
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset valid", 128'(rk_valid), 128'(0));
    chk("reset round", 128'(rk_round), 128'(0));
    chk("reset out", rk_out, 128'(0));
    chk("reset done", 128'(done), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_fips("fips", 0, 0);

    // Zero key.
    key_in = '0;
    start = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      chk($sformatf("zero round r%0d", i), 128'(rk_round), 128'(i));
      if (i == 0)  chk("zero key r0", rk_out, 128'(0));
      if (i == 1)  chk("zero key r1", rk_out, Z1);
      if (i == 10) chk("zero key r10", rk_out, Z10);
      @(negedge clk);
    end
    rk_ready = 1'b0;
    chk("zero done", 128'(done), 128'(1));
    @(negedge clk);

    run_fips("stall", 1, 0);
    run_fips("restart_ignored", 0, 1);

    // Reset in the middle of an expansion.
    key_in = FIPS_KEY;
    start = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && rk_round != 4'd6; i++) @(negedge clk);
    chk("abort reached r6", 128'(rk_round), 128'(6));
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort valid", 128'(rk_valid), 128'(0));
    chk("abort round", 128'(rk_round), 128'(0));
    chk("abort out", rk_out, 128'(0));
    chk("abort done", 128'(done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-abort no done", 128'(done), 128'(0));
    chk("post-abort idle", 128'(rk_valid), 128'(0));

    run_fips("after_reset", 0, 0);

    // ROUNDS=1 build, with a restart in the done cycle.
    key_in1 = '0;
    start1 = 1'b1;
    rk_ready1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("r1 valid k0", 128'(rk_valid1), 128'(1));
    chk("r1 round k0", 128'(rk_round1), 128'(0));
    chk("r1 key k0", rk_out1, 128'(0));
    @(negedge clk);
    chk("r1 round k1", 128'(rk_round1), 128'(1));
    chk("r1 key k1", rk_out1, Z1);
    @(negedge clk);
    chk("r1 done", 128'(done1), 128'(1));
    chk("r1 valid at done", 128'(rk_valid1), 128'(0));
    key_in1 = FIPS_KEY;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("r1 restart valid", 128'(rk_valid1), 128'(1));
    chk("r1 restart round", 128'(rk_round1), 128'(0));
    chk("r1 restart key", rk_out1, fips[0]);
    chk("r1 restart done low", 128'(done1), 128'(0));
    @(negedge clk);
    chk("r1 restart key1", rk_out1, fips[1]);
    @(negedge clk);
    chk("r1 restart done", 128'(done1), 128'(1));
    rk_ready1 = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
